// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory stage: access sizes, FSM states, word geometry.
package data_mem_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int OFFSET_BITS    = 3;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam logic [1:0] MEM_D = 2'b11;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // An access is aligned when the byte offset is a multiple of its size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [OFFSET_BITS-1:0] off);
    logic mis;
    case (size)
      MEM_H:   mis = off[0];
      MEM_W:   mis = |off[1:0];
      MEM_D:   mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// Lane steering: store data/byte-enables shifted into the word, load lanes extracted and extended.
// Purely combinational, no flow control.
module data_mem_align
  import data_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]                size,
  input  logic [OFFSET_BITS-1:0]    offset,
  input  logic                      is_unsigned,
  input  logic [XLEN-1:0]           store_data,
  output logic [XLEN-1:0]           store_word,
  output logic [BYTES_PER_WORD-1:0] byte_en,
  input  logic [XLEN-1:0]           load_word,
  output logic [XLEN-1:0]           load_data
);

  logic [BYTES_PER_WORD-1:0] be_base;
  logic [XLEN-1:0]           shifted;
  logic                      sgn;

  always_comb begin
    case (size)
      MEM_B:   be_base = 8'h01;
      MEM_H:   be_base = 8'h03;
      MEM_W:   be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
    byte_en    = be_base << offset;
    store_word = store_data << {offset, 3'b000};
  end

  always_comb begin
    shifted = load_word >> {offset, 3'b000};
    sgn     = 1'b0;
    case (size)
      MEM_B: begin
        sgn       = ~is_unsigned & shifted[7];
        load_data = {{(XLEN-8){sgn}}, shifted[7:0]};
      end
      MEM_H: begin
        sgn       = ~is_unsigned & shifted[15];
        load_data = {{(XLEN-16){sgn}}, shifted[15:0]};
      end
      MEM_W: begin
        sgn       = ~is_unsigned & shifted[31];
        load_data = {{(XLEN-32){sgn}}, shifted[31:0]};
      end
      default: load_data = shifted;  // double ignores is_unsigned
    endcase
  end

endmodule

// File: rtl/data_mem_stage.sv
// Data memory stage: B/H/W/D loads and stores with wait states; done 1+WAIT_STATES cycles after request.
// mem_busy stalls upstream during the access and the reset sweep.
// DATA_MEM_INIT_CLEAR_EN enables the post-reset zero sweep; otherwise memory survives reset.
module data_mem_stage
  import data_mem_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] WriteData,
  input  logic [4:0]      Rd,
  input  logic            BranchTaken,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [1:0]      MemSize,
  input  logic            MemUnsigned,
  input  logic            MemtoReg,
  input  logic            RegWrite,
  output logic [XLEN-1:0] ReadData,
  output logic [XLEN-1:0] ALUResultOut,
  output logic [4:0]      RdOut,
  output logic            BranchTakenOut,
  output logic            MemtoRegOut,
  output logic            RegWriteOut,
  output logic            mem_busy,
  output logic            mem_done,
  output logic            misaligned,
  output logic            out_of_range
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  logic [XLEN-1:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d, store_q, store_d;
  logic [XLEN-1:0] rdata_q, rdata_d, alu_q, alu_d;
  logic [4:0]      rd_q, rd_d;
  logic            br_q, br_d, m2r_q, m2r_d, rw_q, rw_d;
  logic            mis_q, mis_d, oor_q, oor_d;
`ifdef DATA_MEM_INIT_CLEAR_EN
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
`endif

  logic                      req;
  logic [XLEN-1:0]           acc_addr, acc_wdata;
  logic [1:0]                acc_size;
  logic                      acc_uns, acc_store;
  logic [OFFSET_BITS-1:0]    acc_off;
  logic [IDX_W-1:0]          acc_idx;
  logic                      acc_oor, acc_mis, acc_ok;
  logic [XLEN-1:0]           st_word, ld_data;
  logic [BYTES_PER_WORD-1:0] st_be;
  logic                      commit;
  logic                      mem_we;
  logic [IDX_W-1:0]          mem_idx;
  logic [BYTES_PER_WORD-1:0] mem_be;
  logic [XLEN-1:0]           mem_wdat;

  assign req = MemRead | MemWrite;

  // With no wait states the access commits on the request edge, so use the live inputs in IDLE.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr  = ALUResult;
      acc_wdata = WriteData;
      acc_size  = MemSize;
      acc_uns   = MemUnsigned;
      acc_store = MemWrite;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_uns   = uns_q;
      acc_store = store_q;
    end
    acc_off = acc_addr[OFFSET_BITS-1:0];
    acc_idx = acc_addr[IDX_W+OFFSET_BITS-1:OFFSET_BITS];
    acc_oor = |acc_addr[XLEN-1:IDX_W+OFFSET_BITS];
    acc_mis = is_misaligned(acc_size, acc_off);
    acc_ok  = ~acc_oor & ~acc_mis;
  end

  data_mem_align #(.XLEN(XLEN)) u_align (
    .size        (acc_size),
    .offset      (acc_off),
    .is_unsigned (acc_uns),
    .store_data  (acc_wdata),
    .store_word  (st_word),
    .byte_en     (st_be),
    .load_word   (mem[acc_idx]),
    .load_data   (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    store_d  = store_q;
    rdata_d  = rdata_q;
    alu_d    = alu_q;
    rd_d     = rd_q;
    br_d     = br_q;
    m2r_d    = m2r_q;
    rw_d     = rw_q;
    mis_d    = mis_q;
    oor_d    = oor_q;
`ifdef DATA_MEM_INIT_CLEAR_EN
    clr_idx_d = clr_idx_q;
`endif
    commit   = 1'b0;
    mem_we   = 1'b0;
    mem_idx  = acc_idx;
    mem_be   = st_be;
    mem_wdat = st_word;

    // IDLE and RESP both hand the sideband straight through to writeback.
    if (state_q == ST_IDLE || state_q == ST_RESP) begin
      alu_d   = ALUResult;
      rd_d    = Rd;
      br_d    = BranchTaken;
      m2r_d   = MemtoReg;
      rw_d    = RegWrite;
      rdata_d = '0;
      mis_d   = 1'b0;
      oor_d   = 1'b0;
    end

    case (state_q)
`ifdef DATA_MEM_INIT_CLEAR_EN
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = clr_idx_q;
        mem_be    = '1;
        mem_wdat  = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        if (req) begin
          addr_d  = ALUResult;
          wdata_d = WriteData;
          size_d  = MemSize;
          uns_d   = MemUnsigned;
          store_d = MemWrite;
          if (WS == 4'd0) begin
            commit  = 1'b1;
            state_d = ST_RESP;
          end else begin
            wcnt_d  = WS - 4'd1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      oor_d   = acc_oor;
      mis_d   = acc_mis & ~acc_oor;
      mem_we  = acc_store & acc_ok;
      rdata_d = (!acc_store && acc_ok) ? ld_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DATA_MEM_INIT_CLEAR_EN
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
`else
      state_q   <= ST_IDLE;
`endif
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      br_q    <= 1'b0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      mis_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
`ifdef DATA_MEM_INIT_CLEAR_EN
      clr_idx_q <= clr_idx_d;
`endif
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      br_q    <= br_d;
      m2r_q   <= m2r_d;
      rw_q    <= rw_d;
      mis_q   <= mis_d;
      oor_q   <= oor_d;
    end
  end

  // Storage has no reset so it can map onto block RAM; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (mem_be[b]) mem[mem_idx][b*8 +: 8] <= mem_wdat[b*8 +: 8];
      end
    end
  end

  assign mem_busy       = (state_q == ST_CLEAR) || (state_q == ST_WAIT) || (state_q == ST_IDLE && req);
  assign mem_done       = (state_q == ST_RESP);
  assign misaligned     = mis_q;
  assign out_of_range   = oor_q;
  assign ReadData       = rdata_q;
  assign ALUResultOut   = alu_q;
  assign RdOut          = rd_q;
  assign BranchTakenOut = br_q;
  assign MemtoRegOut    = m2r_q;
  assign RegWriteOut    = rw_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench: zero-wait instance for the access table, two-wait-state instance for stall/reset cases.
module tb_data_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DATA_MEM_INIT_CLEAR_EN
  localparam int          SWEEP1   = 1024;
  localparam int          SWEEP2   = 64;
  localparam logic [63:0] POST_RST = 64'h0;
`else
  localparam int          SWEEP1   = 0;
  localparam int          SWEEP2   = 0;
  localparam logic [63:0] POST_RST = 64'h1111;
`endif

  logic        rst, rst2;
  logic [63:0] alu_in, wdata_in;
  logic [4:0]  rd_in;
  logic        br_in, mrd_in, mwr_in, uns_in, m2r_in, rw_in;
  logic [1:0]  size_in;

  logic [63:0] rdata1, alu1, rdata2, alu2;
  logic [4:0]  rdo1, rdo2;
  logic        bro1, m2ro1, rwo1, busy1, done1, mis1, oor1;
  logic        bro2, m2ro2, rwo2, busy2, done2, mis2, oor2;

  int passed = 0;
  int total  = 0;

  data_mem_stage #(.XLEN(64), .DEPTH(1024), .WAIT_STATES(0)) dut (
    .clk(clk), .reset(rst), .ALUResult(alu_in), .WriteData(wdata_in), .Rd(rd_in),
    .BranchTaken(br_in), .MemRead(mrd_in), .MemWrite(mwr_in), .MemSize(size_in),
    .MemUnsigned(uns_in), .MemtoReg(m2r_in), .RegWrite(rw_in), .ReadData(rdata1),
    .ALUResultOut(alu1), .RdOut(rdo1), .BranchTakenOut(bro1), .MemtoRegOut(m2ro1),
    .RegWriteOut(rwo1), .mem_busy(busy1), .mem_done(done1), .misaligned(mis1),
    .out_of_range(oor1)
  );

  data_mem_stage #(.XLEN(64), .DEPTH(64), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(rst2), .ALUResult(alu_in), .WriteData(wdata_in), .Rd(rd_in),
    .BranchTaken(br_in), .MemRead(mrd_in), .MemWrite(mwr_in), .MemSize(size_in),
    .MemUnsigned(uns_in), .MemtoReg(m2r_in), .RegWrite(rw_in), .ReadData(rdata2),
    .ALUResultOut(alu2), .RdOut(rdo2), .BranchTakenOut(bro2), .MemtoRegOut(m2ro2),
    .RegWriteOut(rwo2), .mem_busy(busy2), .mem_done(done2), .misaligned(mis2),
    .out_of_range(oor2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  int          g_lat, g_busy;
  logic        g_done, g_mis, g_oor, g_rw, g_m2r;
  logic [63:0] g_rdata, g_alu;
  logic [4:0]  g_rd;

  task automatic access(input bit sel, input logic wr, input logic rd, input logic [1:0] sz,
                        input logic un, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [4:0] rdr);
    @(posedge clk); #1;
    alu_in = addr; wdata_in = wd; size_in = sz; uns_in = un;
    mrd_in = rd; mwr_in = wr; rd_in = rdr; rw_in = rd & ~wr; m2r_in = rd; br_in = 1'b0;
    g_lat = 0; g_busy = 0; g_done = 1'b0;
    for (int c = 0; c < 40 && !g_done; c++) begin
      @(negedge clk);
      if (sel ? busy2 : busy1) g_busy++;
      if (sel ? done2 : done1) begin
        g_done  = 1'b1;
        g_rdata = sel ? rdata2 : rdata1;
        g_alu   = sel ? alu2 : alu1;
        g_rd    = sel ? rdo2 : rdo1;
        g_rw    = sel ? rwo2 : rwo1;
        g_m2r   = sel ? m2ro2 : m2ro1;
        g_mis   = sel ? mis2 : mis1;
        g_oor   = sel ? oor2 : oor1;
      end else begin
        g_lat++;
      end
    end
    @(posedge clk); #1;
    mrd_in = 1'b0; mwr_in = 1'b0;
    chk("done seen", 64'(g_done), 64'd1);
  endtask

  task automatic count_busy(input bit sel, output int n);
    n = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (!(sel ? busy2 : busy1)) break;
      n++;
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  sz;
    logic        un;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [4:0]  rdr;
    logic [63:0] exp;
    logic        mis;
    logic        oor;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic rd, input logic [1:0] sz, input logic un,
                              input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rdr,
                              input logic [63:0] exp, input logic mis, input logic oor);
    vec_t v;
    v.wr = wr; v.rd = rd; v.sz = sz; v.un = un; v.addr = addr; v.wd = wd;
    v.rdr = rdr; v.exp = exp; v.mis = mis; v.oor = oor;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int   n;

    vt.push_back(mk(1, 0, 2'b11, 0, 64'h10,   64'hDEADBEEFDEADBEEF, 5'd0,  64'h0, 0, 0));
    vt.push_back(mk(0, 1, 2'b11, 0, 64'h10,   64'h0, 5'd13, 64'hDEADBEEFDEADBEEF, 0, 0));
    vt.push_back(mk(1, 0, 2'b11, 0, 64'h20,   64'h000000008000FF80, 5'd0, 64'h0, 0, 0));
    vt.push_back(mk(0, 1, 2'b00, 0, 64'h20,   64'h0, 5'd5,  64'hFFFFFFFFFFFFFF80, 0, 0));
    vt.push_back(mk(0, 1, 2'b00, 1, 64'h20,   64'h0, 5'd6,  64'h80, 0, 0));
    vt.push_back(mk(0, 1, 2'b01, 0, 64'h22,   64'h0, 5'd7,  64'hFFFFFFFFFFFF8000, 0, 0));
    vt.push_back(mk(0, 1, 2'b10, 1, 64'h20,   64'h0, 5'd8,  64'h8000FF80, 0, 0));
    vt.push_back(mk(0, 1, 2'b10, 0, 64'h20,   64'h0, 5'd9,  64'hFFFFFFFF8000FF80, 0, 0));
    vt.push_back(mk(0, 1, 2'b01, 1, 64'h20,   64'h0, 5'd10, 64'hFF80, 0, 0));
    vt.push_back(mk(0, 1, 2'b00, 1, 64'h23,   64'h0, 5'd11, 64'h80, 0, 0));
    vt.push_back(mk(0, 1, 2'b00, 0, 64'h21,   64'h0, 5'd12, 64'hFFFFFFFFFFFFFFFF, 0, 0));
    vt.push_back(mk(0, 1, 2'b10, 0, 64'h22,   64'h0, 5'd14, 64'h0, 1, 0));
    vt.push_back(mk(1, 0, 2'b10, 0, 64'h22,   64'h12345678, 5'd0, 64'h0, 1, 0));
    vt.push_back(mk(0, 1, 2'b11, 0, 64'h20,   64'h0, 5'd15, 64'h8000FF80, 0, 0));
    vt.push_back(mk(1, 0, 2'b11, 0, 64'h20,   64'h0, 5'd0,  64'h0, 0, 0));
    vt.push_back(mk(1, 0, 2'b00, 0, 64'h23,   64'h11223344556677AA, 5'd0, 64'h0, 0, 0));
    vt.push_back(mk(0, 1, 2'b11, 0, 64'h20,   64'h0, 5'd16, 64'h00000000AA000000, 0, 0));
    vt.push_back(mk(1, 0, 2'b11, 0, 64'h0,    64'h0123456789ABCDEF, 5'd0, 64'h0, 0, 0));
    vt.push_back(mk(1, 0, 2'b11, 0, 64'h2000, 64'hFFFF, 5'd0, 64'h0, 0, 1));
    vt.push_back(mk(0, 1, 2'b11, 0, 64'h0,    64'h0, 5'd17, 64'h0123456789ABCDEF, 0, 0));
    vt.push_back(mk(0, 1, 2'b11, 0, 64'h2004, 64'h0, 5'd18, 64'h0, 0, 1));
    vt.push_back(mk(1, 0, 2'b11, 0, 64'h1FF8, 64'h77, 5'd0, 64'h0, 0, 0));
    vt.push_back(mk(0, 1, 2'b11, 0, 64'h1FF8, 64'h0, 5'd19, 64'h77, 0, 0));
    vt.push_back(mk(1, 1, 2'b01, 0, 64'h40,   64'h1234BEEF, 5'd3, 64'h0, 0, 0));
    vt.push_back(mk(0, 1, 2'b01, 1, 64'h40,   64'h0, 5'd20, 64'hBEEF, 0, 0));
    vt.push_back(mk(0, 1, 2'b01, 0, 64'h40,   64'h0, 5'd21, 64'hFFFFFFFFFFFFBEEF, 0, 0));
    vt.push_back(mk(1, 0, 2'b10, 0, 64'h44,   64'hCAFEF00D, 5'd0, 64'h0, 0, 0));
    vt.push_back(mk(0, 1, 2'b10, 0, 64'h44,   64'h0, 5'd22, 64'hFFFFFFFFCAFEF00D, 0, 0));
    vt.push_back(mk(0, 1, 2'b00, 1, 64'h46,   64'h0, 5'd23, 64'hFE, 0, 0));

    rst = 1'b1; rst2 = 1'b1;
    alu_in = '0; wdata_in = '0; rd_in = '0; br_in = 1'b0; mrd_in = 1'b0; mwr_in = 1'b0;
    size_in = '0; uns_in = 1'b0; m2r_in = 1'b0; rw_in = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ReadData", rdata1, 64'h0);
    chk("reset RdOut", 64'(rdo1), 64'h0);
    chk("reset mem_done", 64'(done1), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(1'b0, n);
    chk("sweep busy cycles", 64'(n), 64'(SWEEP1));

`ifdef DATA_MEM_INIT_CLEAR_EN
    access(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h0, 5'd1);
    chk("cleared word", g_rdata, 64'h0);
`endif

    // Idle pass-through of the writeback sideband.
    @(posedge clk); #1;
    alu_in = 64'h55; rd_in = 5'd7; br_in = 1'b1; m2r_in = 1'b1; rw_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle ALUResultOut", alu1, 64'h55);
    chk("idle RdOut", 64'(rdo1), 64'd7);
    chk("idle BranchTakenOut", 64'(bro1), 64'd1);
    chk("idle ReadData", rdata1, 64'h0);
    chk("idle mem_busy", 64'(busy1), 64'd0);
    chk("idle mem_done", 64'(done1), 64'd0);

    for (int i = 0; i < vt.size(); i++) begin
      access(1'b0, vt[i].wr, vt[i].rd, vt[i].sz, vt[i].un, vt[i].addr, vt[i].wd, vt[i].rdr);
      chk($sformatf("v%0d latency", i), 64'(g_lat), 64'd1);
      chk($sformatf("v%0d ReadData", i), g_rdata, vt[i].exp);
      chk($sformatf("v%0d misaligned", i), 64'(g_mis), 64'(vt[i].mis));
      chk($sformatf("v%0d out_of_range", i), 64'(g_oor), 64'(vt[i].oor));
      chk($sformatf("v%0d RdOut", i), 64'(g_rd), 64'(vt[i].rdr));
      chk($sformatf("v%0d RegWriteOut", i), 64'(g_rw), 64'(vt[i].rd & ~vt[i].wr));
      chk($sformatf("v%0d MemtoRegOut", i), 64'(g_m2r), 64'(vt[i].rd));
      chk($sformatf("v%0d ALUResultOut", i), g_alu, vt[i].addr);
    end

    // Wait-state instance.
    @(posedge clk); #1;
    rst2 = 1'b0;
    count_busy(1'b1, n);
    chk("ws sweep busy cycles", 64'(n), 64'(SWEEP2));

    access(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 64'h30, 64'h1111, 5'd0);
    chk("ws sd latency", 64'(g_lat), 64'd3);
    chk("ws sd busy cycles", 64'(g_busy), 64'd3);
    access(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 64'h30, 64'h0, 5'd4);
    chk("ws ld latency", 64'(g_lat), 64'd3);
    chk("ws ld busy cycles", 64'(g_busy), 64'd3);
    chk("ws ld ReadData", g_rdata, 64'h1111);

    // Reset lands in the middle of a waiting store.
    @(posedge clk); #1;
    alu_in = 64'h30; wdata_in = 64'h2222; size_in = 2'b11; mwr_in = 1'b1; mrd_in = 1'b0;
    @(negedge clk);
    chk("ws req busy", 64'(busy2), 64'd1);
    @(negedge clk);
    chk("ws in wait busy", 64'(busy2), 64'd1);
    chk("ws in wait done", 64'(done2), 64'd0);
    rst2 = 1'b1; mwr_in = 1'b0;
    @(posedge clk); #1;
    chk("ws reset done", 64'(done2), 64'd0);
    chk("ws reset ReadData", rdata2, 64'h0);
    rst2 = 1'b0;
    count_busy(1'b1, n);
    chk("ws resweep busy cycles", 64'(n), 64'(SWEEP2));
    access(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 64'h30, 64'h0, 5'd4);
    chk("ws post-reset ld", g_rdata, POST_RST);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
